// File: rtl/stream_pkg.sv
// Shared types and constants for the streaming round-robin multiplexer.
package stream_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Channel index width; a 1-channel index would otherwise collapse to 0 bits.
  function automatic int ch_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational rotate-then-priority-encode arbiter: first requester at or after ptr wins.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  input  logic              enable,
  output logic [CH_W-1:0]   grant,
  output logic              grant_valid
);

  int idx;

  // Walk downward so the lowest rotated offset is the last (winning) assignment.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (enable && req[idx]) begin
        grant       = CH_W'(idx);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream mux with registered output, fixed or round-robin arbitration
// and packet locking until the beat carrying last has transferred.
//   state     | meaning
//   ST_IDLE   | between packets; grant comes from sel or the round-robin arbiter
//   ST_LOCKED | mid-packet; grant pinned to lock_ch_q until the last beat transfers
module stream_mux_rr
  import stream_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int MODE   = 1,
  parameter int CH_W   = ch_width(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_last,
  input  logic [CH_W-1:0]          sel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic [CH_W-1:0]          out_ch
);

  state_e              state_q, state_d;
  logic [CH_W-1:0]     lock_ch_q, lock_ch_d;
  logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_last_q, out_last_d;
  logic [CH_W-1:0]     out_ch_q, out_ch_d;

  logic                load;
  logic [CH_W-1:0]     arb_grant, grant;
  logic                arb_gv, fixed_gv, grant_valid;
  logic                xfer, xfer_last;
  logic [DATA_W-1:0]   xfer_data;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .req         (in_valid),
    .ptr         (rr_ptr_q),
    .enable      ((MODE == MODE_RR) && (state_q == ST_IDLE)),
    .grant       (arb_grant),
    .grant_valid (arb_gv)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      lock_ch_q   <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      lock_ch_q   <= lock_ch_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_ch_q    <= out_ch_d;
    end
  end

  // Grant selection and handshake; an out-of-range sel simply never matches a channel.
  always_comb begin
    load     = !out_valid_q || out_ready;
    fixed_gv = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel == CH_W'(i) && in_valid[i]) fixed_gv = 1'b1;
    end
    if (state_q == ST_LOCKED) begin
      grant       = lock_ch_q;
      grant_valid = 1'b1;
    end else if (MODE == MODE_RR) begin
      grant       = arb_grant;
      grant_valid = arb_gv;
    end else begin
      grant       = sel;
      grant_valid = fixed_gv;
    end
    in_ready  = '0;
    xfer      = 1'b0;
    xfer_last = 1'b0;
    xfer_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant == CH_W'(i)) begin
        in_ready[i] = load && grant_valid;
        xfer        = in_valid[i] && load && grant_valid;
        xfer_last   = in_last[i];
        xfer_data   = in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    lock_ch_d   = lock_ch_q;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_ch_d    = out_ch_q;
    if (load) out_valid_d = xfer;
    if (xfer) begin
      out_data_d = xfer_data;
      out_last_d = xfer_last;
      out_ch_d   = grant;
      if (xfer_last) begin
        state_d  = ST_IDLE;
        rr_ptr_d = (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
      end else begin
        state_d   = ST_LOCKED;
        lock_ch_d = grant;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench: a 4-channel round-robin instance and a 3-channel fixed-select instance.
module tb_stream_mux_rr;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  in_valid_a = '0, in_last_a = '0, in_ready_a;
  logic [31:0] in_data_a = '0;
  logic [1:0]  sel_a = '0, out_ch_a;
  logic        out_valid_a, out_ready_a = 1'b1, out_last_a;
  logic [7:0]  out_data_a;

  logic [2:0]  in_valid_b = '0, in_last_b = '0, in_ready_b;
  logic [23:0] in_data_b = '0;
  logic [1:0]  sel_b = '0, out_ch_b;
  logic        out_valid_b, out_ready_b = 1'b1, out_last_b;
  logic [7:0]  out_data_b;

  stream_mux_rr #(.NUM_CH(4), .DATA_W(8), .MODE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data_a), .in_last(in_last_a), .sel(sel_a), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .out_data(out_data_a), .out_last(out_last_a), .out_ch(out_ch_a)
  );

  stream_mux_rr #(.NUM_CH(3), .DATA_W(8), .MODE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .in_last(in_last_b), .sel(sel_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .out_data(out_data_b), .out_last(out_last_b), .out_ch(out_ch_b)
  );

  int n_checks = 0;
  int n_err = 0;
  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] beat(input logic [1:0] ch, input logic [7:0] d, input logic l);
    return {21'd0, ch, d, l};
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid_a && out_ready_a) begin
      if (exp_a.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL a_beat: got 0x%0h, expected none", beat(out_ch_a, out_data_a, out_last_a));
      end else chk("a_beat", beat(out_ch_a, out_data_a, out_last_a), exp_a.pop_front());
    end
    if (rst_n && out_valid_b && out_ready_b) begin
      if (exp_b.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL b_beat: got 0x%0h, expected none", beat(out_ch_b, out_data_b, out_last_b));
      end else chk("b_beat", beat(out_ch_b, out_data_b, out_last_b), exp_b.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] rr_seq[5];
    rr_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    #3;
    chk("reset_out_valid", 32'(out_valid_a), 0);
    chk("reset_out_data", 32'(out_data_a), 0);
    step();
    rst_n = 1'b1;

    // Round-robin fairness with single-beat packets on every channel.
    for (int k = 0; k < 5; k++) begin
      step();
      in_valid_a = 4'hF; in_last_a = 4'hF; in_data_a = 32'h13121110;
      #3;
      chk("rr_ready", 32'(in_ready_a), 32'(4'b0001 << rr_seq[k]));
      if (k > 0) chk("rr_out_ch_latency", 32'(out_ch_a), 32'(rr_seq[k-1]));
      exp_a.push_back(beat(rr_seq[k], 8'h10 + 8'(rr_seq[k]), 1'b1));
    end
    step(); in_valid_a = '0;

    // Packet lock on ch1, including a valid gap, while ch2 waits.
    step(); in_valid_a = 4'b0110; in_last_a = 4'b0100; in_data_a = 32'h00B0A100;
    #3; chk("lock_a1_ready", 32'(in_ready_a), 32'b0010); exp_a.push_back(beat(2'd1, 8'hA1, 1'b0));
    step(); in_valid_a = 4'b0100;
    #3; chk("lock_gap_ready", 32'(in_ready_a), 32'b0010);
    step(); in_valid_a = 4'b0110; in_data_a = 32'h00B0A200;
    #3; chk("lock_a2_ready", 32'(in_ready_a), 32'b0010); exp_a.push_back(beat(2'd1, 8'hA2, 1'b0));
    step(); in_last_a = 4'b0110; in_data_a = 32'h00B0A300;
    #3; chk("lock_a3_ready", 32'(in_ready_a), 32'b0010); exp_a.push_back(beat(2'd1, 8'hA3, 1'b1));
    step(); in_valid_a = 4'b0100;
    #3; chk("after_lock_ready", 32'(in_ready_a), 32'b0100); exp_a.push_back(beat(2'd2, 8'hB0, 1'b1));
    step(); in_valid_a = '0;

    // Backpressure: 0x5A held for three cycles, then the next beat loads as it drains.
    step(); in_valid_a = 4'b1000; in_last_a = 4'b1000; in_data_a = 32'h5A000000; out_ready_a = 1'b0;
    #3; chk("bp_load_ready", 32'(in_ready_a), 32'b1000); exp_a.push_back(beat(2'd3, 8'h5A, 1'b1));
    step(); in_valid_a = 4'b0001; in_last_a = 4'b0001; in_data_a = 32'h00000077;
    for (int k = 0; k < 3; k++) begin
      #3;
      chk("bp_hold_data", 32'(out_data_a), 32'h5A);
      chk("bp_hold_valid", 32'(out_valid_a), 1);
      chk("bp_ready_zero", 32'(in_ready_a), 0);
      if (k < 2) step();
    end
    step(); out_ready_a = 1'b1;
    #3; chk("bp_release_ready", 32'(in_ready_a), 32'b0001); exp_a.push_back(beat(2'd0, 8'h77, 1'b1));
    step(); in_valid_a = '0;

    // Asynchronous reset in the middle of a packet, with a beat sitting in the output register.
    step(); in_valid_a = 4'b0010; in_last_a = 4'b0000; in_data_a = 32'h0000C100; out_ready_a = 1'b0;
    #3; chk("rst_pkt_ready", 32'(in_ready_a), 32'b0010);
    step(); in_valid_a = '0;
    #1; chk("rst_pre_valid", 32'(out_valid_a), 1);
    chk("rst_pre_data", 32'(out_data_a), 32'hC1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 32'(out_valid_a), 0);
    chk("rst_async_data", 32'(out_data_a), 0);
    chk("rst_async_ch", 32'(out_ch_a), 0);
    step(); rst_n = 1'b1; out_ready_a = 1'b1;
    step(); in_valid_a = 4'hF; in_last_a = 4'hF; in_data_a = 32'h43424140;
    #3; chk("post_rst_ptr_ready", 32'(in_ready_a), 32'b0001); exp_a.push_back(beat(2'd0, 8'h40, 1'b1));
    step(); in_valid_a = '0;

    // Fixed select: sel moves mid-packet but ch2 keeps the grant.
    step(); sel_b = 2'd2; in_valid_b = 3'b101; in_last_b = 3'b001; in_data_b = 24'hD100E0;
    #3; chk("fix_d1_ready", 32'(in_ready_b), 32'b100); exp_b.push_back(beat(2'd2, 8'hD1, 1'b0));
    step(); sel_b = 2'd0; in_last_b = 3'b101; in_data_b = 24'hD200E0;
    #3; chk("fix_d2_ready", 32'(in_ready_b), 32'b100); exp_b.push_back(beat(2'd2, 8'hD2, 1'b1));
    step(); in_valid_b = 3'b001;
    #3; chk("fix_ch0_ready", 32'(in_ready_b), 32'b001); exp_b.push_back(beat(2'd0, 8'hE0, 1'b1));
    step(); in_valid_b = '0;

    // Out-of-range sel on a 3-channel instance waits without transferring.
    step(); sel_b = 2'd3; in_valid_b = 3'b111; in_last_b = 3'b111; in_data_b = 24'hF2F1F0;
    for (int k = 0; k < 3; k++) begin
      #3;
      chk("oor_ready", 32'(in_ready_b), 0);
      chk("oor_out_valid", 32'(out_valid_b), 0);
      step();
    end
    sel_b = 2'd1;
    #3; chk("oor_recover_ready", 32'(in_ready_b), 32'b010); exp_b.push_back(beat(2'd1, 8'hF1, 1'b1));
    step(); in_valid_b = '0;

    repeat (4) @(posedge clk);
    #1;
    chk("a_queue_empty", 32'(exp_a.size()), 0);
    chk("b_queue_empty", 32'(exp_b.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
